// File: rtl/fp8_add_sequencer.sv
// fp8 (1/4/3, bias 7) adder sequencer: special-case screen, align, add, normalize.
// Ports: clk, rst (async high), in_valid/in_ready + a/b in, out_valid/out_ready + q/exc/ovf out, busy.
module fp8_add_sequencer #(
  parameter int ALIGN_CLAMP = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] q,
  output logic       exc,
  output logic       ovf,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    ALIGN,
    ADD,
    NORM,
    DONE
  } state_t;

  localparam logic [3:0] CLAMP = 4'(ALIGN_CLAMP);

  state_t     state;
  logic [7:0] ra;
  logic [7:0] rb;
  logic [7:0] sig_l;
  logic [7:0] sig_s;
  logic [3:0] exp_r;
  logic       sign_r;
  logic       sub_r;

  logic [3:0] ea;
  logic [3:0] eb;
  logic [2:0] ma;
  logic [2:0] mb;
  logic       nan_a;
  logic       nan_b;
  logic       inf_a;
  logic       inf_b;
  logic       zero_a;
  logic       zero_b;
  logic [7:0] sig_a;
  logic [7:0] sig_b;
  logic [3:0] eff_a;
  logic [3:0] eff_b;

  assign ea     = ra[6:3];
  assign eb     = rb[6:3];
  assign ma     = ra[2:0];
  assign mb     = rb[2:0];
  assign nan_a  = (ea == 4'hf) && (ma != 3'd0);
  assign nan_b  = (eb == 4'hf) && (mb != 3'd0);
  assign inf_a  = (ea == 4'hf) && (ma == 3'd0);
  assign inf_b  = (eb == 4'hf) && (mb == 3'd0);
  assign zero_a = (ra[6:0] == 7'd0);
  assign zero_b = (rb[6:0] == 7'd0);
  // Subnormals have no hidden bit and sit at effective exponent 1.
  assign sig_a  = {ea != 4'd0, ma, 4'b0000};
  assign sig_b  = {eb != 4'd0, mb, 4'b0000};
  assign eff_a  = (ea == 4'd0) ? 4'd1 : ea;
  assign eff_b  = (eb == 4'd0) ? 4'd1 : eb;

  // Special-case screen, highest priority first.
  logic       spec_hit;
  logic [7:0] spec_q;

  always_comb begin
    spec_hit = 1'b1;
    spec_q   = 8'h00;
    if (nan_a && nan_b) begin
      spec_q = {ra[7], 4'hf, (ma < mb) ? ma : mb};
    end else if (nan_a) begin
      spec_q = ra;
    end else if (nan_b) begin
      spec_q = rb;
    end else if (inf_a) begin
      spec_q = ra;
    end else if (inf_b) begin
      spec_q = rb;
    end else if (zero_a) begin
      spec_q = rb;
    end else if (zero_b) begin
      spec_q = ra;
    end else begin
      spec_hit = 1'b0;
    end
  end

  // Alignment: ties in exponent are broken by mantissa, then favour A.
  logic       a_big;
  logic [3:0] diff;
  logic [3:0] shamt;
  logic [7:0] big_sig;
  logic [7:0] small_sig;
  logic [3:0] big_e;
  logic       big_sign;

  always_comb begin
    a_big = (ea > eb) || ((ea == eb) && (ma >= mb));
    if (a_big) begin
      big_sig   = sig_a;
      small_sig = sig_b;
      big_e     = eff_a;
      big_sign  = ra[7];
      diff      = eff_a - eff_b;
    end else begin
      big_sig   = sig_b;
      small_sig = sig_a;
      big_e     = eff_b;
      big_sign  = rb[7];
      diff      = eff_b - eff_a;
    end
    shamt = (diff > CLAMP) ? CLAMP : diff;
  end

  // Add / subtract of aligned magnitudes.
  logic [8:0] sum9;
  logic [7:0] add_m;
  logic [3:0] add_e;
  logic       add_ovf;

  always_comb begin
    sum9    = {1'b0, sig_l} + {1'b0, sig_s};
    add_m   = sum9[7:0];
    add_e   = exp_r;
    add_ovf = 1'b0;
    if (sub_r) begin
      add_m = sig_l - sig_s;
    end else if (sum9[8]) begin
      add_m   = sum9[8:1];
      add_e   = exp_r + 4'd1;
      add_ovf = (exp_r == 4'd14);
    end
  end

  // One normalize step per NORM cycle.
  logic [7:0] nrm_m;
  logic [3:0] nrm_e;

  assign nrm_m = {sig_l[6:0], 1'b0};
  assign nrm_e = exp_r - 4'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      ra        <= 8'h00;
      rb        <= 8'h00;
      sig_l     <= 8'h00;
      sig_s     <= 8'h00;
      exp_r     <= 4'd0;
      sign_r    <= 1'b0;
      sub_r     <= 1'b0;
      q         <= 8'h00;
      exc       <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            ra       <= a;
            rb       <= b;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= CHECK;
          end
        end
        CHECK: begin
          ovf <= 1'b0;
          if (spec_hit) begin
            q         <= spec_q;
            exc       <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            exc   <= 1'b0;
            state <= ALIGN;
          end
        end
        ALIGN: begin
          sig_l  <= big_sig;
          sig_s  <= small_sig >> shamt;
          exp_r  <= big_e;
          sign_r <= big_sign;
          sub_r  <= ra[7] ^ rb[7];
          state  <= ADD;
        end
        ADD: begin
          if (add_ovf) begin
            q         <= {sign_r, 4'hf, 3'b000};
            ovf       <= 1'b1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (add_m == 8'h00) begin
            q         <= 8'h00;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (add_m[7] || (add_e == 4'd1)) begin
            // Already normalized (or pinned at the subnormal floor).
            q         <= {sign_r, add_m[7] ? add_e : 4'd0, add_m[6:4]};
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            sig_l <= add_m;
            exp_r <= add_e;
            state <= NORM;
          end
        end
        NORM: begin
          if (nrm_m[7] || (nrm_e == 4'd1)) begin
            q         <= {sign_r, nrm_m[7] ? nrm_e : 4'd0, nrm_m[6:4]};
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            sig_l <= nrm_m;
            exp_r <= nrm_e;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp8_add_sequencer.sv
// Testbench for fp8_add_sequencer: directed plan vectors plus random pairs
// checked against an arithmetic reference model.
module tb_fp8_add_sequencer;

  localparam int CLAMP = 7;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] q;
  logic       exc;
  logic       ovf;
  logic       busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp8_add_sequencer #(.ALIGN_CLAMP(CLAMP)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .exc       (exc),
    .ovf       (ovf),
    .busy      (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference: scaled-integer arithmetic on significands (value = m * 2^(e-14)).
  task automatic model(input logic [7:0] x, input logic [7:0] y,
                       output logic [7:0] rq, output logic rexc,
                       output logic rovf, output int rlat);
    int ex, ey, mx, my, vx, vy, fx, fy;
    int mbig, msml, ebig, d, m, e, n;
    bit sbig, xbig;
    ex = int'(x[6:3]);
    ey = int'(y[6:3]);
    mx = int'(x[2:0]);
    my = int'(y[2:0]);
    rexc = 1'b1;
    rovf = 1'b0;
    rlat = 2;
    rq   = 8'h00;
    if (ex == 15 && mx != 0 && ey == 15 && my != 0)
      rq = {x[7], 4'hf, 3'((mx < my) ? mx : my)};
    else if (ex == 15 && mx != 0) rq = x;
    else if (ey == 15 && my != 0) rq = y;
    else if (ex == 15) rq = x;
    else if (ey == 15) rq = y;
    else if (ex == 0 && mx == 0) rq = y;
    else if (ey == 0 && my == 0) rq = x;
    else begin
      rexc = 1'b0;
      rlat = 4;
      vx = ((ex != 0) ? 8 + mx : mx) * 16;
      vy = ((ey != 0) ? 8 + my : my) * 16;
      fx = (ex == 0) ? 1 : ex;
      fy = (ey == 0) ? 1 : ey;
      xbig = (ex > ey) || (ex == ey && mx >= my);
      if (xbig) begin
        mbig = vx; msml = vy; ebig = fx; d = fx - fy; sbig = x[7];
      end else begin
        mbig = vy; msml = vx; ebig = fy; d = fy - fx; sbig = y[7];
      end
      if (d > CLAMP) d = CLAMP;
      msml = msml / (1 << d);
      m = (x[7] == y[7]) ? mbig + msml : mbig - msml;
      e = ebig;
      if (m >= 256) begin
        m = m / 2;
        e = e + 1;
      end
      if (e == 15) begin
        rovf = 1'b1;
        rq   = {sbig, 4'hf, 3'b000};
      end else if (m == 0) begin
        rq = 8'h00;
      end else begin
        n = 0;
        while (m < 128 && e > 1) begin
          m = m * 2;
          e = e - 1;
          n = n + 1;
        end
        rq   = {sbig, (m >= 128) ? 4'(e) : 4'd0, 3'((m / 16) % 8)};
        rlat = 4 + n;
      end
    end
  endtask

  // One transaction: accept, wait for result, hold for `hold` cycles, release.
  task automatic txn(input logic [7:0] x, input logic [7:0] y,
                     input int hold, input bit early, input string tag);
    logic [7:0] eq;
    logic       ee;
    logic       eo;
    int         el;
    int         lat;
    model(x, y, eq, ee, eo, el);
    @(negedge clk);
    chk($sformatf("%s_in_ready_idle", tag), 32'(in_ready), 32'd1);
    a = x;
    b = y;
    in_valid = 1'b1;
    if (early) out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 64) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk($sformatf("%s_out_valid", tag), 32'(out_valid), 32'd1);
    chk($sformatf("%s_latency", tag), 32'(lat), 32'(el));
    chk($sformatf("%s_q(%h+%h)", tag, x, y), 32'(q), 32'(eq));
    chk($sformatf("%s_exc", tag), 32'(exc), 32'(ee));
    chk($sformatf("%s_ovf", tag), 32'(ovf), 32'(eo));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk($sformatf("%s_hold_q", tag), 32'(q), 32'(eq));
      chk($sformatf("%s_hold_valid", tag), 32'(out_valid), 32'd1);
      chk($sformatf("%s_hold_in_ready", tag), 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk($sformatf("%s_released", tag), 32'(out_valid), 32'd0);
    chk($sformatf("%s_in_ready_after", tag), 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = 8'h00;
    b         = 8'h00;
    repeat (2) @(negedge clk);
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_exc", 32'(exc), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst = 1'b0;

    // Directed plan vectors.
    txn(8'h38, 8'h38, 0, 1'b0, "add_1p1");
    txn(8'h38, 8'h3C, 0, 1'b0, "add_1p1_5");
    txn(8'h79, 8'h3A, 0, 1'b0, "nan_a");
    txn(8'h79, 8'h7B, 0, 1'b0, "nan_both");
    txn(8'h78, 8'hB8, 0, 1'b0, "inf_a");
    txn(8'h00, 8'h42, 0, 1'b0, "zero_a");
    txn(8'h38, 8'hB8, 0, 1'b0, "cancel");
    txn(8'h40, 8'hBC, 0, 1'b0, "norm2");
    txn(8'h77, 8'h77, 0, 1'b0, "overflow");
    txn(8'h3A, 8'h31, 0, 1'b1, "early_ready");
    txn(8'h01, 8'h81, 0, 1'b0, "sub_cancel");
    txn(8'h07, 8'h07, 0, 1'b0, "subn_sum");
    txn(8'h70, 8'h08, 0, 1'b0, "clamp");

    // Backpressure with a competing operand pair held on the input.
    @(negedge clk);
    a = 8'h38;
    b = 8'h3C;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    a = 8'h40;
    b = 8'hBC;
    for (int i = 0; i < 20 && out_valid !== 1'b1; i++) begin
      @(posedge clk);
      #1;
    end
    chk("bp_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_q", 32'(q), 32'h42);
      chk("bp_exc", 32'(exc), 32'd0);
      chk("bp_ovf", 32'(ovf), 32'd0);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("bp_in_ready_next", 32'(in_ready), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_ignored_busy", 32'(busy), 32'd0);

    // Reset while in NORM.
    @(negedge clk);
    a = 8'h40;
    b = 8'hBC;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_q", 32'(q), 32'h00);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    txn(8'h38, 8'h38, 0, 1'b0, "post_rst");

    // Random pairs against the reference model.
    for (int i = 0; i < 300; i++) begin
      txn(8'($urandom), 8'($urandom), int'($urandom_range(0, 2)),
          1'b0, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
